// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the write port of the async FIFO between NUM_REQ producers in the
// write-clock domain. Arbitration is round-robin, and each grant carries a
// burst of at most BURST_LEN words. FULL back-pressure is honoured.
// W_INC and WR_DATA are combinational, so the FIFO samples them on the same
// W_CLK edge that consumes the requester's word.
//
// Ports:
//   W_CLK     write-domain clock; all state changes on the rising edge
//   W_RST     asynchronous active-low reset
//   REQ       per-requester "word pending"
//   REQ_DATA  requester k word at [k*DATA_WIDTH +: DATA_WIDTH]
//   GNT       one-hot; REQ & GNT marks the word consumed on this edge
//   FULL      FIFO full flag (write domain)
//   W_INC     FIFO write enable
//   WR_DATA   FIFO write data (zero when not writing)
//   BUSY      high while a burst is in progress
//   OWNER     index of the current or last burst owner
//   WR_CNT    16-bit write counter, present only with FIFO_ARB_CNT_EN
//
// Optional feature macro: FIFO_ARB_CNT_EN adds WR_CNT.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate; no transfer; pick next owner starting at ptr_q
// ST_BURST | transfer words of owner_q until BURST_LEN, REQ drop or reset

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                            W_CLK,
  input  logic                            W_RST,
  input  logic [NUM_REQ-1:0]              REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]              GNT,
  input  logic                            FULL,
  output logic                            W_INC,
  output logic [DATA_WIDTH-1:0]           WR_DATA,
  output logic                            BUSY,
`ifdef FIFO_ARB_CNT_EN
  output logic [15:0]                     WR_CNT,
`endif
  output logic [$clog2(NUM_REQ)-1:0]      OWNER
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

  logic                pick_vld;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     cand;
  logic                owner_req;
  logic                w_inc;
  logic                busy;

  // Explicit wrap so non-power-of-2 NUM_REQ never lands on an unused index.
  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

  // Round-robin search: ptr_q, ptr_q+1, ... ; first hit wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && REQ[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
      cand = inc_id(cand);
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    w_inc     = 1'b0;
    busy      = 1'b0;
    owner_req = REQ[owner_q];

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_id;
          bcnt_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        busy  = 1'b1;
        w_inc = owner_req & ~FULL;
        if (!owner_req) begin
          // A REQ drop ends the burst even if FULL releases in the same cycle.
          state_d = ST_IDLE;
          ptr_d   = inc_id(owner_q);
        end else if (w_inc) begin
          if (bcnt_q == BCNT_W'(BURST_LEN - 1)) begin
            state_d = ST_IDLE;
            ptr_d   = inc_id(owner_q);
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
        // FULL with REQ held: stall, everything holds.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign W_INC   = w_inc;
  assign GNT     = w_inc ? (GNT_ONE << owner_q) : '0;
  assign WR_DATA = w_inc ? REQ_DATA[int'(owner_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
  assign BUSY    = busy;
  assign OWNER   = owner_q;

`ifdef FIFO_ARB_CNT_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;

  // Wraps 16'hFFFF -> 0 naturally.
  always_comb begin
    wr_cnt_d = wr_cnt_q + 16'(w_inc);
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign WR_CNT = wr_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: requester queues drive REQ/REQ_DATA, the
// expected FIFO write stream is queued by hand per test, and a monitor on the
// falling edge pops and compares every W_INC cycle.

module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BL = 4;

  logic             W_CLK = 1'b0;
  logic             W_RST = 1'b0;
  logic [NR-1:0]    REQ = '0;
  logic [NR*DW-1:0] REQ_DATA = '0;
  logic             FULL = 1'b0;
  logic [NR-1:0]    GNT;
  logic             W_INC;
  logic [DW-1:0]    WR_DATA;
  logic             BUSY;
  logic [1:0]       OWNER;
`ifdef FIFO_ARB_CNT_EN
  logic [15:0]      WR_CNT;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rq[NR][$];

  always #5 W_CLK = ~W_CLK;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .W_CLK   (W_CLK),
    .W_RST   (W_RST),
    .REQ     (REQ),
    .REQ_DATA(REQ_DATA),
    .GNT     (GNT),
    .FULL    (FULL),
    .W_INC   (W_INC),
    .WR_DATA (WR_DATA),
    .BUSY    (BUSY),
`ifdef FIFO_ARB_CNT_EN
    .WR_CNT  (WR_CNT),
`endif
    .OWNER   (OWNER)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input int k, input logic [7:0] d);
    exp_t e;
    e.owner = 2'(k);
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_req();
    for (int k = 0; k < NR; k++) begin
      REQ[k] = (rq[k].size() != 0);
      REQ_DATA[k*DW +: DW] = REQ[k] ? rq[k][0] : 8'h00;
    end
  endtask

  // One clock: capture transfers before the edge, consume them after it,
  // then apply the next FULL value. Returns at posedge + 2.
  task automatic tick(input logic full_next);
    logic [NR-1:0] xfer;
    logic [7:0]    junk;
    @(negedge W_CLK);
    xfer = GNT & REQ;
    @(posedge W_CLK);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (xfer[k] && rq[k].size() != 0) junk = rq[k].pop_front();
    end
    FULL = full_next;
    drive_req();
    #1;
  endtask

  task automatic do_reset();
    @(posedge W_CLK);
    #2;
    W_RST = 1'b0;
    FULL  = 1'b0;
    for (int k = 0; k < NR; k++) rq[k].delete();
    drive_req();
    #1;
    check("reset_gnt", 32'(GNT), 32'h0);
    check("reset_w_inc", 32'(W_INC), 32'h0);
    check("reset_wr_data", 32'(WR_DATA), 32'h0);
    check("reset_busy", 32'(BUSY), 32'h0);
    check("reset_owner", 32'(OWNER), 32'h0);
    check("missing_writes", 32'(exp_q.size()), 32'h0);
`ifdef FIFO_ARB_CNT_EN
    check("reset_wr_cnt", 32'(WR_CNT), 32'h0);
`endif
    exp_q.delete();
    @(posedge W_CLK);
    #2;
    W_RST = 1'b1;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge W_CLK);
      if (W_INC === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got data %0h gnt %b expected no write", WR_DATA, GNT);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", 32'(WR_DATA), 32'(e.data));
          check("wr_gnt", 32'(GNT), 32'(4'b0001 << e.owner));
          check("no_overflow_full", 32'(FULL), 32'h0);
        end
      end else begin
        check("idle_gnt", 32'(GNT), 32'h0);
        check("idle_wr_data", 32'(WR_DATA), 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0]  t1_winc, t1_busy;
    logic [8:0]  t3_winc, t3_busy, t3_full;
    logic [7:0]  t4_winc, t4_busy;

    // ---------- 1: single requester, 6 words ----------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rq[0].push_back(8'(8'hA0 + i));
      expect_wr(0, 8'(8'hA0 + i));
    end
    drive_req();
    #1;
    t1_winc = 10'b0011011110;
    t1_busy = 10'b0111011110;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick(1'b0);
      check($sformatf("t1_w_inc[%0d]", i), 32'(W_INC), 32'(t1_winc[i]));
      check($sformatf("t1_busy[%0d]", i), 32'(BUSY), 32'(t1_busy[i]));
    end
    check("t1_owner", 32'(OWNER), 32'h0);
    check("t1_ptr", 32'(dut.ptr_q), 32'h1);

    // ---------- 2: all requesters active ----------
    do_reset();
    for (int k = 0; k < NR; k++) begin
      for (int i = 0; i < ((k == 0) ? 8 : 4); i++) rq[k].push_back(8'(k * 16 + i));
    end
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) expect_wr(b, 8'(b * 16 + i));
    end
    for (int i = 4; i < 8; i++) expect_wr(0, 8'(i));
    drive_req();
    #1;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) tick(1'b0);
      check($sformatf("t2_w_inc[%0d]", i), 32'(W_INC), 32'((i % 5) != 0));
      if ((i % 5) == 1) check($sformatf("t2_owner[%0d]", i), 32'(OWNER), 32'((i / 5) % 4));
    end
    tick(1'b0);
    check("t2_busy_end", 32'(BUSY), 32'h0);

    // ---------- 3: FULL stall mid-burst ----------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rq[2].push_back(8'(8'hC0 + i));
      expect_wr(2, 8'(8'hC0 + i));
    end
    drive_req();
    #1;
    t3_full = 9'b000111000;
    t3_winc = 9'b011000110;
    t3_busy = 9'b011111110;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick(t3_full[i]);
      check($sformatf("t3_w_inc[%0d]", i), 32'(W_INC), 32'(t3_winc[i]));
      check($sformatf("t3_busy[%0d]", i), 32'(BUSY), 32'(t3_busy[i]));
      if (t3_full[i]) begin
        check($sformatf("t3_bcnt[%0d]", i), 32'(dut.bcnt_q), 32'h2);
        check($sformatf("t3_gnt[%0d]", i), 32'(GNT), 32'h0);
      end
    end

    // ---------- 4: owner drops REQ after one write ----------
    do_reset();
    rq[1].push_back(8'hB0);
    rq[3].push_back(8'hE0);
    rq[3].push_back(8'hE1);
    expect_wr(1, 8'hB0);
    expect_wr(3, 8'hE0);
    expect_wr(3, 8'hE1);
    drive_req();
    #1;
    t4_winc = 8'b00110010;
    t4_busy = 8'b01110110;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick(1'b0);
      check($sformatf("t4_w_inc[%0d]", i), 32'(W_INC), 32'(t4_winc[i]));
      check($sformatf("t4_busy[%0d]", i), 32'(BUSY), 32'(t4_busy[i]));
      if (i == 3) check("t4_ptr", 32'(dut.ptr_q), 32'h2);
      if (i == 4) check("t4_owner", 32'(OWNER), 32'h3);
    end

    // ---------- 5: reset mid-burst ----------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rq[2].push_back(8'(8'hD0 + i));
      expect_wr(2, 8'(8'hD0 + i));
    end
    drive_req();
    #1;
    tick(1'b0);
    check("t5_owner_pre", 32'(OWNER), 32'h2);
    tick(1'b0);
    check("t5_bcnt_pre", 32'(dut.bcnt_q), 32'h1);
    check("t5_w_inc_pre", 32'(W_INC), 32'h1);
    W_RST = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(GNT), 32'h0);
    check("t5_rst_w_inc", 32'(W_INC), 32'h0);
    check("t5_rst_busy", 32'(BUSY), 32'h0);
    check("t5_rst_owner", 32'(OWNER), 32'h0);
    tick(1'b0);
    W_RST = 1'b1;
    check("t5_req_kept", 32'(REQ), 32'h4);
    tick(1'b0);
    check("t5_regrant_owner", 32'(OWNER), 32'h2);
    check("t5_regrant_w_inc", 32'(W_INC), 32'h1);
    for (int i = 0; i < 4; i++) tick(1'b0);
    check("t5_busy_end", 32'(BUSY), 32'h0);
    check("t5_rq_empty", 32'(rq[2].size()), 32'h0);

`ifdef FIFO_ARB_CNT_EN
    // ---------- 6: write counter ----------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rq[0].push_back(8'(8'h50 + i));
      expect_wr(0, 8'(8'h50 + i));
    end
    for (int i = 0; i < 3; i++) begin
      rq[1].push_back(8'(8'h60 + i));
      rq[2].push_back(8'(8'h70 + i));
    end
    for (int i = 0; i < 3; i++) expect_wr(1, 8'(8'h60 + i));
    for (int i = 0; i < 3; i++) expect_wr(2, 8'(8'h70 + i));
    drive_req();
    for (int i = 1; i <= 30; i++) tick((i % 4) == 1);
    tick(1'b0);
    check("t6_wr_cnt", 32'(WR_CNT), 32'd10);
    force dut.wr_cnt_q = 16'hFFFF;
    #1;
    release dut.wr_cnt_q;
    rq[3].push_back(8'h99);
    expect_wr(3, 8'h99);
    drive_req();
    for (int i = 0; i < 6; i++) tick(1'b0);
    check("t6_wr_cnt_wrap", 32'(WR_CNT), 32'h0);
`endif

    tick(1'b0);
    check("end_missing_writes", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of the async FIFO (ASYNC_FIFO_TOP) between NUM_REQ independent producers in the write-clock domain.
- Round-robin arbitration with bounded bursts (up to BURST_LEN words per grant).
- Honours FIFO FULL back-pressure and drives the FIFO W_INC/WR_DATA directly, so the FIFO samples them on the same W_CLK edge.

Parameters:
- DATA_WIDTH, 8, width of each data word (matches the FIFO).
- NUM_REQ, 4, number of requesters (>=2).
- BURST_LEN, 4, maximum words written per grant (>=1).
- Localparam ID_W = $clog2(NUM_REQ).

Ports:
- W_CLK  input  1  write-domain clock; all state on rising edge.
- W_RST  input  1  asynchronous, active-low reset.
- REQ  input  NUM_REQ  requester k has a valid word pending.
- REQ_DATA  input  NUM_REQ*DATA_WIDTH  requester k word at [k*DATA_WIDTH +: DATA_WIDTH].
- GNT  output  NUM_REQ  one-hot; word of requester k is consumed on this edge (REQ&GNT = transfer).
- FULL  input  1  FIFO full flag (write domain).
- W_INC  output  1  FIFO write enable.
- WR_DATA  output  DATA_WIDTH  FIFO write data.
- BUSY  output  1  high while in BURST.
- OWNER  output  ID_W  index of current/last burst owner.
- WR_CNT  output  16  only with FIFO_ARB_CNT_EN.

Behaviour:
- States: IDLE (arbitrate), BURST (transfer). Registers: state, OWNER, PTR (ID_W), BCNT ($clog2(BURST_LEN)+1 bits).
- Reset (W_RST=0, async): state=IDLE, OWNER=0, PTR=0, BCNT=0. Outputs: GNT=0, W_INC=0, WR_DATA=0, BUSY=0.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Else pick the first k with REQ[k]=1, searching PTR, PTR+1, ... mod NUM_REQ.
  - Load OWNER=k, BCNT=0, go to BURST.
  - No transfer occurs in the IDLE cycle (1-cycle arbitration latency).
- BURST, combinational outputs:
  - W_INC = REQ[OWNER] & ~FULL.
  - GNT = W_INC ? (1<<OWNER) : 0.
  - WR_DATA = W_INC ? REQ_DATA slice OWNER : 0.
  - BUSY=1.
- BURST transitions:
  - Transfer with BCNT==BURST_LEN-1: go to IDLE, PTR=OWNER+1 mod NUM_REQ.
  - Transfer otherwise: BCNT+1, stay in BURST.
  - REQ[OWNER]=0: go to IDLE with no transfer, PTR=OWNER+1 mod NUM_REQ.
  - FULL=1 with REQ[OWNER]=1: stall. No transfer, BCNT and OWNER hold, stay in BURST.
- Requester contract:
  - A requester must hold REQ and its data stable until GNT.
  - It may drop REQ only when not granted.
- Wrap: PTR and OWNER wrap NUM_REQ-1 -> 0. For non-power-of-2 NUM_REQ the compare is explicit (no natural overflow).
- Fairness: each burst is followed by exactly one IDLE cycle. With all requesters active, each is served once per NUM_REQ bursts.
- Simultaneous FULL deassert and REQ drop in the same cycle: REQ drop wins, burst ends with no write.
- Reset mid-burst: W_INC/GNT drop immediately (async). The in-flight word is not written and the requester keeps it.
- Never asserts W_INC while FULL=1 (no overflow), given FULL is valid in W_CLK domain.

Optional Feature:
- Macro FIFO_ARB_CNT_EN.
- Defined: adds output WR_CNT[15:0], the count of W_INC cycles. Reset 0; +1 per write; wraps 16'hFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Only REQ[0]=1 with 6 words, FULL=0 -> 4 consecutive W_INC/GNT[0] cycles, 1 IDLE cycle, then 2 more writes. OWNER=0 throughout, PTR=1 after; FIFO reads back the 6 words in order.
2. All REQ=4'b1111 continuously, FULL=0 -> OWNER sequence 0,1,2,3,0. Each burst is 4 writes; bursts repeat every 5 cycles; GNT always one-hot.
3. REQ[2] only; FULL=1 for 3 cycles after the 2nd write -> W_INC=0, GNT=0, BCNT holds at 2, BUSY=1. After FULL=0, 2 more writes, then IDLE.
4. REQ[1],REQ[3] active; REQ[1] drops after 1 write -> burst ends with no write that cycle. Next grant goes to requester 3; PTR=2 during that arbitration.
5. W_RST low mid-burst (OWNER=2, BCNT=1) -> GNT=0, W_INC=0, BUSY=0, OWNER=0 immediately. After release with REQ=4'b0100, arbitration restarts and grants requester 2.
6. FIFO_ARB_CNT_EN defined, 10 writes spread over 3 owners with FULL stalls -> WR_CNT=10. Force 16'hFFFF plus 1 write -> WR_CNT=0.
